// File: rtl/dpram_pkg.sv
// Shared definitions for the dual-port RAM port master, the RAM and its bench.
// Holds the state encoding and the default RAM geometry.
package dpram_pkg;

  localparam int unsigned DPRAM_AW = 4;
  localparam int unsigned DPRAM_DW = 8;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_DATA,
    TURN,
    VRD_ADDR,
    VRD_DATA
  } dpram_state_t;

endpackage

// File: rtl/dpram_port_master.sv
// Single-beat read/write initiator for one port of the shared-bus dual-port RAM.
// Optional write read-back check is enabled by defining DPRAM_WR_VERIFY_EN.
module dpram_port_master
  import dpram_pkg::*;
#(
  parameter int unsigned AW = DPRAM_AW,
  parameter int unsigned DW = DPRAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] ram_ad,
  output logic          ram_we,
  output logic          ram_re,
  inout  wire  [DW-1:0] ram_data
`ifdef DPRAM_WR_VERIFY_EN
  ,
  output logic          vfy_err
`endif
);

  dpram_state_t  state;
  logic [DW-1:0] wdata_q;

  assign req_ready = (state == IDLE);

  // Bus is released as soon as ram_we drops, including on asynchronous reset.
  assign ram_data = (ram_we && !ram_re) ? wdata_q : 'z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ram_ad    <= '0;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef DPRAM_WR_VERIFY_EN
      vfy_err   <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
`ifdef DPRAM_WR_VERIFY_EN
      vfy_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_valid) begin
            ram_ad  <= req_addr;
            wdata_q <= req_wdata;
            if (req_write) begin
              ram_we <= 1'b1;
              state  <= WRITE;
            end else begin
              ram_re <= 1'b1;
              state  <= RD_ADDR;
            end
          end
        end
        WRITE: begin
          ram_we <= 1'b0;
`ifdef DPRAM_WR_VERIFY_EN
          ram_re <= 1'b1;
          state  <= VRD_ADDR;
`else
          rsp_valid <= 1'b1;
          state     <= IDLE;
`endif
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          ram_re    <= 1'b0;
          rsp_rdata <= ram_data;
          rsp_valid <= 1'b1;
          state     <= TURN;
        end
        TURN: state <= IDLE;
`ifdef DPRAM_WR_VERIFY_EN
        VRD_ADDR: state <= VRD_DATA;
        VRD_DATA: begin
          ram_re    <= 1'b0;
          rsp_rdata <= ram_data;
          rsp_valid <= 1'b1;
          vfy_err   <= (ram_data != wdata_q);
          state     <= TURN;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_port_master.sv
// Randomised and directed bench for dpram_port_master against a behavioural
// shared-bus RAM; honours DPRAM_WR_VERIFY_EN when defined.
module tb_dpram_port_master;
  import dpram_pkg::*;

  localparam int unsigned AW = DPRAM_AW;
  localparam int unsigned DW = DPRAM_DW;
`ifdef DPRAM_WR_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] ram_ad;
  logic          ram_we;
  logic          ram_re;
  wire  [DW-1:0] ram_data;
`ifdef DPRAM_WR_VERIFY_EN
  logic          vfy_err;
  logic          last_vfy = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  dpram_port_master #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_ad    (ram_ad),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_data  (ram_data)
`ifdef DPRAM_WR_VERIFY_EN
    ,
    .vfy_err   (vfy_err)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural RAM: one port, clocked on posedge or negedge, optional stuck-at-0 mask.
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] ram_q = '0;
  logic          use_neg = 1'b0;
  logic [DW-1:0] stuck = '0;

  assign ram_data = ram_re ? ram_q : 'z;

  always @(posedge clk or negedge clk) begin
    if (clk != use_neg) begin
      if (ram_we) mem[ram_ad] <= ram_data & ~stuck;
      if (ram_re) ram_q <= mem[ram_ad];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: memory image, outstanding-request queue, spec latencies.
  typedef struct {
    int            cyc;
    bit            wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  logic [DW-1:0] ref_mem [1<<AW];
  txn_t          q[$];
  int            cyc = 0;
  int            n_acc = 0;
  int            n_rsp = 0;
  logic [DW-1:0] last_rdata = '0;
  bit            prev_ready = 1'b0;

  function automatic int lat(input bit wr);
    if (!wr) return 2;
    return VFY ? 3 : 1;
  endfunction

  initial begin : monitor
    txn_t t;
    txn_t h;
    bit   due;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        n_acc -= q.size();
        q.delete();
        last_rdata = '0;
      end else begin
        if (prev_ready && req_valid) begin
          t.cyc   = cyc;
          t.wr    = req_write;
          t.wdata = req_wdata;
          if (req_write) ref_mem[req_addr] = req_wdata & ~stuck;
          t.rdata = ref_mem[req_addr];
          q.push_back(t);
          n_acc++;
        end
        chk("we_re_excl", {31'b0, ram_we & ram_re}, 32'd0);
        if (q.size() > 0) begin
          h   = q[0];
          due = (cyc == h.cyc + lat(h.wr));
          chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, due});
          chk("req_ready_busy", {31'b0, req_ready}, {31'b0, due && h.wr && !VFY});
          if (ram_we) chk("bus_wdata", {24'b0, ram_data}, {24'b0, h.wdata});
          if (due) begin
            if (!h.wr || VFY) last_rdata = h.rdata;
`ifdef DPRAM_WR_VERIFY_EN
            chk("vfy_err", {31'b0, vfy_err}, {31'b0, h.wr && (h.rdata != h.wdata)});
            last_vfy = vfy_err;
`endif
            n_rsp++;
            q.delete(0);
          end
`ifdef DPRAM_WR_VERIFY_EN
          else chk("vfy_err_quiet", {31'b0, vfy_err}, 32'd0);
`endif
        end else begin
          chk("rsp_valid_idle", {31'b0, rsp_valid}, 32'd0);
          chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        end
        chk("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, last_rdata});
      end
      prev_ready = req_ready;
    end
  end

  task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_timeout", q.size(), 32'd0);
  endtask

  task automatic sweep(input string tag);
    logic [AW-1:0] a;
    logic [DW-1:0] e;
    for (int unsigned i = 0; i < 16; i++) do_req(1'b1, AW'(i), DW'(8'h10 + i));
    a = '0;
    for (int unsigned i = 0; i < 17; i++) begin
      do_req(1'b0, a, DW'($urandom));
      e = DW'(8'h10 + (i % 16));
      chk(tag, {24'b0, rsp_rdata}, {24'b0, e});
      a = a + 1'b1;
    end
  endtask

  initial begin : driver
    int unsigned k;
    int unsigned n;
    bit          prev;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    #1 rst = 1'b1;
    #2;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {24'b0, rsp_rdata}, 32'd0);
    chk("rst_ram_ad", {28'b0, ram_ad}, 32'd0);
    chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
    chk("rst_ram_re", {31'b0, ram_re}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_req(1'b1, 4'd3, 8'hA5);
    do_req(1'b0, 4'd3, 8'h00);
    chk("rd_a5", {24'b0, rsp_rdata}, 32'hA5);

    sweep("sweep_pos");

    // Back-to-back alternating write/read with req_valid held.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 4'd7;
    req_wdata = 8'h3C;
    prev = req_ready;
    k = 0;
    n = 0;
    while (k < 8 && n < 60) begin
      @(negedge clk);
      n++;
      if (prev) begin
        k++;
        req_write = ~req_write;
      end
      prev = req_ready;
    end
    req_valid = 1'b0;
    chk("b2b_accepts", k, 32'd8);
    repeat (6) @(negedge clk);
    chk("b2b_rdata", {24'b0, rsp_rdata}, 32'h3C);

    // Randomised mix.
    for (int unsigned i = 0; i < 40; i++) begin
      ra = AW'($urandom);
      rd = DW'($urandom);
      do_req(1'($urandom), ra, rd);
    end

    // Asynchronous reset in the middle of RD_DATA.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'd5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_re", {31'b0, ram_re}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_ram_re", {31'b0, ram_re}, 32'd0);
    chk("arst_bus_drv", {31'b0, ram_we & ~ram_re}, 32'd0);
    chk("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("arst_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);

    use_neg = 1'b1;
    sweep("sweep_neg");
    use_neg = 1'b0;

`ifdef DPRAM_WR_VERIFY_EN
    do_req(1'b1, 4'd9, 8'h5A);
    chk("vfy_ok", {31'b0, last_vfy}, 32'd0);
    chk("vfy_ok_rdata", {24'b0, rsp_rdata}, 32'h5A);
    stuck = 8'h02;
    do_req(1'b1, 4'd9, 8'h02);
    chk("vfy_stuck", {31'b0, last_vfy}, 32'd1);
    chk("vfy_stuck_rdata", {24'b0, rsp_rdata}, 32'h00);
    stuck = '0;
`endif

    repeat (5) @(negedge clk);
    chk("drain", q.size(), 32'd0);
    chk("rsp_count", n_rsp, n_acc);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
